// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ
// byte-stream requesters, with optional packet locking and hold timeout.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter bit LOCK_PKT     = 1'b1,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_rdy_i,
    output logic               busy_o,
    output logic               timeout_o,
    output logic [15:0]        byte_cnt_o
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            lock_q, lock_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic            timeout_q, timeout_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   scan_idx;
    logic [N_REQ-1:0] ready;
    logic            xfer;
    logic [PW-1:0]   xfer_idx;
    logic [N_REQ-1:0] grant;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            scan_idx = PW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Ready is masked during reset so every output reads zero at once.
    always_comb begin
        ready = '0;
        unique case (state_q)
            IDLE:    if (win_found && reset_i) ready[win_idx] = 1'b1;
            DONE:    if (lock_q) ready[owner_q] = req_valid_i[owner_q];
            HOLD:    ready[owner_q] = req_valid_i[owner_q];
            default: ready = '0;
        endcase
    end

    assign xfer     = |(ready & req_valid_i);
    assign xfer_idx = (state_q == IDLE) ? win_idx : owner_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        hold_cnt_d = hold_cnt_q;
        tx_data_d  = tx_data_q;
        byte_cnt_d = byte_cnt_q;
        timeout_d  = 1'b0;
        if (xfer) begin
            tx_data_d = req_data_i[{xfer_idx, 3'b000} +: 8];
            owner_d   = xfer_idx;
            lock_d    = LOCK_PKT && !req_last_i[xfer_idx];
        end
        unique case (state_q)
            IDLE:  if (xfer) state_d = START;
            START: state_d = WAIT;
            WAIT:  if (tx_rdy_i) state_d = DONE;
            DONE: begin
                byte_cnt_d = byte_cnt_q + 16'd1;
                if (!lock_q) begin
                    rr_ptr_d = owner_q;
                    state_d  = IDLE;
                end else if (xfer) begin
                    state_d = START;
                end else begin
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_d = START;
                end else if (hold_cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
                    timeout_d  = 1'b1;
                    lock_d     = 1'b0;
                    rr_ptr_d   = owner_q;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PW'(N_REQ - 1);
            owner_q    <= '0;
            lock_q     <= 1'b0;
            hold_cnt_q <= '0;
            tx_data_q  <= '0;
            byte_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            hold_cnt_q <= hold_cnt_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q != IDLE) grant[owner_q] = 1'b1;
    end

    assign req_ready_o = ready;
    assign grant_o     = grant;
    assign tx_start_o  = (state_q == START);
    assign tx_data_o   = tx_data_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = timeout_q;
    assign byte_cnt_o  = byte_cnt_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N byte-stream requesters using round-robin arbitration with optional packet locking.
- Accepts bytes over a valid/ready handshake and launches the transmitter with a one-cycle tx_start_o pulse.
- Waits for the transmitter's frame-done pulse before serving the next byte.
- Sits between the command/response producers and the UART TX core; the TX core's send FSM is driven solely from this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LOCK_PKT, 1, when 1 the grant is held until the requester sends a byte with last set.
- HOLD_TIMEOUT, 1024, cycles a locked grant waits for the next byte before forced release (>=2).

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  per-requester byte valid
- req_data_i  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]
- req_last_i  in  N_REQ  per-requester last byte of packet
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
- grant_o  out  N_REQ  one-hot current owner; zero when idle
- tx_start_o  out  1  one-cycle launch pulse to UART TX
- tx_data_o  out  8  byte to UART TX; stable from START until the next capture
- tx_rdy_i  in  1  one-cycle pulse from UART TX when the frame is complete
- busy_o  out  1  high in any state other than IDLE
- timeout_o  out  1  one-cycle pulse on forced lock release
- byte_cnt_o  out  16  bytes completed since reset; wraps at 65535 -> 0

Behaviour:
- Reset (asynchronous, reset_i=0): state=IDLE, rr_ptr=N_REQ-1, owner=0, lock=0, hold_cnt=0, tx_data_o=0, byte_cnt_o=0. All outputs are 0.
- A transfer occurs on a clock edge where req_valid_i[k] and req_ready_o[k] are both 1. On that edge: tx_data_o <= byte k, owner <= k, lock <= LOCK_PKT & ~req_last_i[k].
- req_ready_o is combinational from the state and req_valid_i. Asserting it never depends on tx_rdy_i.

State machine (states IDLE, START, WAIT, DONE, HOLD):
- IDLE:
  - Winner is the first valid requester searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - req_ready_o[winner]=1. On transfer go to START; otherwise stay in IDLE.
- START:
  - tx_start_o=1 for exactly this one cycle; grant_o=onehot(owner).
  - Next state is WAIT unconditionally.
- WAIT:
  - tx_rdy_i=1 -> DONE; otherwise remain in WAIT.
  - tx_rdy_i is ignored in every state except WAIT.
- DONE (one cycle):
  - byte_cnt_o increments.
  - If lock=0: rr_ptr <= owner, go to IDLE. No requester is served in this cycle.
  - If lock=1 and req_valid_i[owner]=1: req_ready_o[owner]=1, transfer, go to START. Other requesters' valid is ignored.
  - If lock=1 and req_valid_i[owner]=0: hold_cnt <= 0, go to HOLD.
- HOLD:
  - grant_o=onehot(owner); req_ready_o[owner]=req_valid_i[owner]; other requesters are never readied.
  - On transfer go to START.
  - Otherwise hold_cnt increments. When hold_cnt==HOLD_TIMEOUT-1: timeout_o=1, lock <= 0, rr_ptr <= owner, go to IDLE.
  - If a transfer and expiry occur in the same cycle, the transfer wins and no timeout is signalled.

Output and latency rules:
- grant_o is onehot(owner) in START, WAIT, DONE and HOLD; 0 in IDLE.
- Latency: transfer edge -> tx_start_o high on the following cycle. tx_rdy_i pulse -> next byte from a locked owner can be accepted 1 cycle later (in DONE), so tx_start_o follows 2 cycles after tx_rdy_i.
- Requesters must hold data stable while valid=1 and ready=0. A requester dropping valid before transfer is legal; arbitration re-evaluates each cycle.
- req_last_i is sampled only at transfer. With LOCK_PKT=0, req_last_i is ignored and every byte re-arbitrates.

Test Plan:
- Single byte: req_valid_i=0001, data 0x55, last=1 -> ready[0] for 1 cycle; tx_start_o pulses the next cycle with tx_data_o=0x55; tx_rdy_i pulse -> byte_cnt_o=1, return to IDLE, busy_o=0.
- Round-robin: all four requesters valid with last=1, bytes 0xA0..0xA3, tx_rdy_i returned 10 cycles after each start -> service order 0,1,2,3,0.
- Packet lock: req0 sends 3 bytes (last on the third) while req1 is continuously valid -> req1 is not granted until after the third tx_rdy_i; grant_o stays 0001 throughout.
- Hold timeout with HOLD_TIMEOUT=8: req0 sends a byte with last=0 then drops valid -> timeout_o pulses exactly 8 cycles after entering HOLD; a waiting req2 is granted next.
- Transfer at expiry: req0 reasserts valid in the cycle hold_cnt==7 -> transfer is accepted and timeout_o stays 0.
- Reset mid-frame: assert reset_i in WAIT -> all outputs are 0 immediately (asynchronously); after release, a spurious tx_rdy_i is ignored and requester 0 has first priority.
